tick_divider: RTL
=================

Name: tick_divider

Overview:
- Multi-channel, runtime-programmable tick generator.
- Each channel emits a one-cycle strobe every D clock cycles and a square wave of period 2·D.
- Sits between the host register interface and the step/timing logic. Provides per-channel base rates (step-rate timebases, PWM prescalers) from the single system clock.
- The divisor of each channel can be changed on the fly; the change is glitch-free.

Parameters:
- NumChannels, 4, number of independent divider channels (1..16).
- DivWidth, 16, width of the divisor and the internal counter (2..32).
- ResetDivisor, 10, divisor every channel holds after reset; must be ≥1 and < 2^DivWidth.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  NumChannels  per-channel run enable, level sensitive.
- cfg_valid  in  1  divisor-update request.
- cfg_ready  out  1  update accepted when cfg_valid && cfg_ready.
- cfg_channel  in  $clog2(NumChannels) (min 1)  target channel index.
- cfg_divisor  in  DivWidth  new divisor D; 0 means stop.
- tick  out  NumChannels  one-cycle strobe per period.
- clk_out  out  NumChannels  toggles on every tick (50% duty, period 2·D).
- running  out  NumChannels  channel state is RUN.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high.
  - All outputs are registered except cfg_ready.
- Reset:
  - State IDLE, counter 0.
  - Active and shadow divisor = ResetDivisor; pending = 0.
  - tick = 0, clk_out = 0, running = 0.
- Per-channel FSM, two states:
  - IDLE → RUN: when enable=1 and active divisor ≠ 0. The counter loads D−1.
  - RUN, counter > 0: decrement.
  - RUN, counter = 0: tick=1 in the next cycle, clk_out toggles, and the counter reloads. The reload value is (shadow−1) if pending, else (active−1). If pending, active := shadow and pending clears at that same edge.
  - RUN → IDLE: when enable=0. Exit is immediate on the next edge. Counter is cleared, tick is forced 0, and clk_out holds its last value.
  - RUN → IDLE also occurs when a divisor of 0 becomes active at a terminal count.
- Timing:
  - First tick is asserted exactly D cycles after the edge that sampled enable=1.
  - Spacing between ticks is exactly D cycles.
  - D=1 gives tick high every cycle and clk_out toggling every cycle.
- Config handshake:
  - cfg_ready = !pending[cfg_channel] (combinational on the select).
  - Accepted write to an IDLE channel: updates active directly; pending stays 0.
  - Accepted write to a RUN channel: writes shadow and sets pending. The new D applies at the next terminal count, so the current period always completes.
  - A second write to the same channel stalls (cfg_ready=0) until pending clears.
  - An out-of-range cfg_channel (≥NumChannels) is accepted and dropped.
- Simultaneous events:
  - Write accepted in the same cycle that channel reaches its terminal count: the reload uses the old value, and the new D applies one period later. No write is lost.
  - enable falling at a terminal count: IDLE wins; tick is not asserted.
  - reset overrides everything, including pending updates.
- Width: the counter is DivWidth bits; D = 2^DivWidth−1 is legal; no wrap beyond the reload.

Optional Feature:
- Macro: TICK_DIVIDER_SYNC_EN.
- When defined:
  - Adds input sync_restart (1 bit).
  - When high, every RUN channel reloads its counter with (active−1) and forces clk_out = 0.
  - The next tick on all channels therefore lands D_i cycles later, phase-aligning the channels.
  - Pending shadows are kept.
  - IDLE channels are unaffected.
- When undefined: the port is absent and there is no restart path.

Decomposition:
- tick_divider_pkg:
  - Channel state enum {IDLE, RUN}.
  - DivWidth-independent constants.
  - A function computing the channel-index width (min 1).
- Sub-module tick_divider_channel holds one channel's FSM, counter, active/shadow/pending and outputs.
- The top generates NumChannels instances plus the cfg decode and the cfg_ready mux.

Test Plan:
- Reset, then enable channel 0 with ResetDivisor=10 → first tick 10 cycles after enable; ticks every 10 cycles; clk_out period 20; running=1.
- Channel 1 idle: write D=3, then enable → ticks every 3 cycles; cfg_ready stays 1 throughout.
- Channel 0 running with D=10: write D=4 mid-period → current period still 10, then ticks every 4. A second write issued before that terminal count sees cfg_ready=0 until the terminal count.
- D=1 on channel 2 → tick constantly high and clk_out toggling every cycle. Then write D=0 → channel stops at the next terminal count; running=0, tick=0.
- Drop enable at the terminal-count cycle → no tick. Assert reset mid-period while pending=1 → all outputs 0; re-enable uses ResetDivisor=10.
- With TICK_DIVIDER_SYNC_EN: channels at D=5 and D=7 free-running; pulse sync_restart → ticks 5 and 7 cycles later respectively, and clk_out is 0 on both after the pulse.

Source files
------------

// File: rtl/tick_divider_pkg.sv
// Shared types and helpers for the multi-channel tick divider.
package tick_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int MAX_CHANNELS  = 16;
    localparam int MIN_DIV_WIDTH = 2;
    localparam int MAX_DIV_WIDTH = 32;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_divider_channel.sv
// One divider channel: IDLE/RUN FSM, down-counter, active/shadow divisor.
// Optional TICK_DIVIDER_SYNC_EN adds a phase-aligning sync_restart input.
module tick_divider_channel
    import tick_divider_pkg::*;
#(
    parameter int DivWidth     = 16,
    parameter int ResetDivisor = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
`ifdef TICK_DIVIDER_SYNC_EN
    input  logic                sync_restart,
`endif
    input  logic                wr,
    input  logic [DivWidth-1:0] wr_divisor,
    output logic                tick,
    output logic                clk_out,
    output logic                running,
    output logic                pending
);

    localparam logic [DivWidth-1:0] RESET_DIV = DivWidth'(ResetDivisor);
    localparam logic [DivWidth-1:0] ONE       = DivWidth'(1);

    ch_state_t           state, state_n;
    logic [DivWidth-1:0] cnt, cnt_n;
    logic [DivWidth-1:0] active, active_n;
    logic [DivWidth-1:0] shadow, shadow_n;
    logic [DivWidth-1:0] eff;
    logic                pending_n, tick_n, clk_out_n;
    logic                restart;

`ifdef TICK_DIVIDER_SYNC_EN
    assign restart = sync_restart;
`else
    assign restart = 1'b0;
`endif

    assign running = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            active  <= RESET_DIV;
            shadow  <= RESET_DIV;
            pending <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            active  <= active_n;
            shadow  <= shadow_n;
            pending <= pending_n;
            tick    <= tick_n;
            clk_out <= clk_out_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        active_n  = active;
        shadow_n  = shadow;
        pending_n = pending;
        tick_n    = 1'b0;
        clk_out_n = clk_out;
        eff       = wr ? wr_divisor : active;
        case (state)
            IDLE: begin
                active_n = eff;
                if (enable && (eff != '0)) begin
                    state_n = RUN;
                    cnt_n   = eff - ONE;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Leaving RUN folds any outstanding update into active so it is not lost.
                    state_n   = IDLE;
                    cnt_n     = '0;
                    active_n  = wr ? wr_divisor : (pending ? shadow : active);
                    pending_n = 1'b0;
                end else begin
                    if (wr) begin
                        shadow_n  = wr_divisor;
                        pending_n = 1'b1;
                    end
                    if (restart) begin
                        cnt_n     = active - ONE;
                        clk_out_n = 1'b0;
                    end else if (cnt == '0) begin
                        if (pending && (shadow == '0)) begin
                            state_n   = IDLE;
                            active_n  = shadow;
                            pending_n = 1'b0;
                        end else if (pending) begin
                            active_n  = shadow;
                            pending_n = 1'b0;
                            cnt_n     = shadow - ONE;
                            tick_n    = 1'b1;
                            clk_out_n = !clk_out;
                        end else begin
                            cnt_n     = active - ONE;
                            tick_n    = 1'b1;
                            clk_out_n = !clk_out;
                        end
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/tick_divider.sv
// Multi-channel programmable tick divider: channel array, cfg decode, cfg_ready mux.
// Optional TICK_DIVIDER_SYNC_EN adds sync_restart for phase alignment.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int NumChannels  = 4,
    parameter int DivWidth     = 16,
    parameter int ResetDivisor = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
`ifdef TICK_DIVIDER_SYNC_EN
    input  logic                                 sync_restart,
`endif
    input  logic [NumChannels-1:0]               enable,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [chan_width(NumChannels)-1:0]   cfg_channel,
    input  logic [DivWidth-1:0]                  cfg_divisor,
    output logic [NumChannels-1:0]               tick,
    output logic [NumChannels-1:0]               clk_out,
    output logic [NumChannels-1:0]               running
);

    localparam int ChW    = chan_width(NumChannels);
    localparam int NumSel = 2 ** ChW;

    logic [NumChannels-1:0] pend;
    logic [NumChannels-1:0] wr;
    logic [NumSel-1:0]      pend_ext;

    // Unused select codes read as never-pending so such writes are accepted and dropped.
    for (genvar g = 0; g < NumSel; g++) begin : g_pend
        if (g < NumChannels) begin : g_real
            assign pend_ext[g] = pend[g];
        end else begin : g_pad
            assign pend_ext[g] = 1'b0;
        end
    end

    assign cfg_ready = !pend_ext[cfg_channel];

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        assign wr[g] = cfg_valid && cfg_ready && (cfg_channel == ChW'(g));

        tick_divider_channel #(
            .DivWidth    (DivWidth),
            .ResetDivisor(ResetDivisor)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .enable      (enable[g]),
`ifdef TICK_DIVIDER_SYNC_EN
            .sync_restart(sync_restart),
`endif
            .wr          (wr[g]),
            .wr_divisor  (cfg_divisor),
            .tick        (tick[g]),
            .clk_out     (clk_out[g]),
            .running     (running[g]),
            .pending     (pend[g])
        );
    end

endmodule
